// File: rtl/div_pkg.sv
// Shared constants and helpers for the iterative divider.
package div_pkg;

    localparam int WIDTH = 32;
    localparam int CNT_W = $clog2(WIDTH) + 1;
    localparam logic [WIDTH-1:0] DIV0_QUOT = '1;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [WIDTH-1:0] abs_neg(input logic [WIDTH-1:0] x, input logic neg);
        return neg ? (~x + 1'b1) : x;
    endfunction

endpackage

// File: rtl/divide.sv
// Restoring shift/subtract divider: one quotient bit per clock, signed or unsigned.
// Handshake: start is accepted only on an edge where ready=1; ready stays low for
// exactly WIDTH cycles, and quotient/remainder are final whenever ready=1.
module divide
    import div_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    input  logic             sign,
    output logic             ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] quo_sr;
    logic [WIDTH-1:0] dvsr;
    logic [WIDTH-1:0] dvnd_raw;
    logic             neg_q;
    logic             neg_r;
    logic             div0;

    logic [WIDTH:0]   trial;
    logic [WIDTH-1:0] acc_nx;
    logic [WIDTH-1:0] quo_nx;

    assign ready = (count == '0);

    // Partial remainder shifts in the next dividend bit; keep the difference if it fits.
    always_comb begin
        trial  = {acc, quo_sr[WIDTH-1]} - {1'b0, dvsr};
        acc_nx = {acc[WIDTH-2:0], quo_sr[WIDTH-1]};
        quo_nx = {quo_sr[WIDTH-2:0], 1'b0};
        if (!trial[WIDTH]) begin
            acc_nx = trial[WIDTH-1:0];
            quo_nx = {quo_sr[WIDTH-2:0], 1'b1};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count     <= '0;
            acc       <= '0;
            quo_sr    <= '0;
            dvsr      <= '0;
            dvnd_raw  <= '0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            div0      <= 1'b0;
            quotient  <= '0;
            remainder <= '0;
        end else if (ready) begin
            if (start) begin
                count    <= CNT_W'(WIDTH);
                acc      <= '0;
                quo_sr   <= abs_neg(dividend, sign & dividend[WIDTH-1]);
                dvsr     <= abs_neg(divisor, sign & divisor[WIDTH-1]);
                dvnd_raw <= dividend;
                div0     <= (divisor == '0);
                neg_q    <= sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                neg_r    <= sign & dividend[WIDTH-1];
            end
        end else begin
            count  <= count - CNT_W'(1);
            acc    <= acc_nx;
            quo_sr <= quo_nx;
            // Final step: apply sign fix-up, or the raw divide-by-zero result.
            if (count == CNT_W'(1)) begin
                if (div0) begin
                    quotient  <= DIV0_QUOT;
                    remainder <= dvnd_raw;
                end else begin
                    quotient  <= abs_neg(quo_nx, neg_q);
                    remainder <= abs_neg(acc_nx, neg_r);
                end
            end
        end
    end

endmodule

// File: tb/tb_divide.sv
// Directed vector table plus handshake, reset and random-op sequences for divide.
module tb_divide;
    import div_pkg::*;

    logic             clk;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             sign;
    logic             ready;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;

    int total = 0;
    int bad   = 0;

    logic [WIDTH-1:0] exp_q[$];

    typedef struct {
        string            name;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             s;
        logic [WIDTH-1:0] eq;
        logic [WIDTH-1:0] er;
    } vec_t;

    vec_t vecs[11];

    divide dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .sign      (sign),
        .ready     (ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Independent reference built on the simulator's own division operators.
    task automatic ref_div(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic s,
                           output logic [WIDTH-1:0] q, output logic [WIDTH-1:0] r);
        if (b == 0) begin
            q = 32'hFFFF_FFFF;
            r = a;
        end else if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
            q = 32'h8000_0000;
            r = 0;
        end else if (s) begin
            q = $signed(a) / $signed(b);
            r = $signed(a) % $signed(b);
        end else begin
            q = a / b;
            r = a % b;
        end
    endtask

    // driver: accept one op, then count cycles until ready returns
    task automatic do_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, output int lat);
        int guard;
        guard = 0;
        while (!ready && guard < 100) begin
            @(posedge clk); #1;
            guard++;
        end
        @(negedge clk);
        dividend = a;
        divisor  = b;
        sign     = s;
        start    = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check({name, "_busy"}, {31'd0, ready}, 32'd0);
        lat = 0;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        logic [WIDTH-1:0] a, b, q, r, eq, er;
        logic s;

        vecs[0]  = '{"u_100_7",     32'h64,         32'h7,         1'b0, 32'h0000000E, 32'h00000002};
        vecs[1]  = '{"u_div0",      32'h12345678,   32'h0,         1'b0, 32'hFFFFFFFF, 32'h12345678};
        vecs[2]  = '{"s_div0",      32'h12345678,   32'h0,         1'b1, 32'hFFFFFFFF, 32'h12345678};
        vecs[3]  = '{"s_neg_div0",  32'hFFFFFFF9,   32'h0,         1'b1, 32'hFFFFFFFF, 32'hFFFFFFF9};
        vecs[4]  = '{"s_m7_2",      32'hFFFFFFF9,   32'h2,         1'b1, 32'hFFFFFFFD, 32'hFFFFFFFF};
        vecs[5]  = '{"u_big_2",     32'hFFFFFFF9,   32'h2,         1'b0, 32'h7FFFFFFC, 32'h00000001};
        vecs[6]  = '{"s_7_m2",      32'h7,          32'hFFFFFFFE,  1'b1, 32'hFFFFFFFD, 32'h00000001};
        vecs[7]  = '{"s_overflow",  32'h80000000,   32'hFFFFFFFF,  1'b1, 32'h80000000, 32'h00000000};
        vecs[8]  = '{"s_m100_m7",   32'hFFFFFF9C,   32'hFFFFFFF9,  1'b1, 32'h0000000E, 32'hFFFFFFFE};
        vecs[9]  = '{"u_max_1",     32'hFFFFFFFF,   32'h1,         1'b0, 32'hFFFFFFFF, 32'h00000000};
        vecs[10] = '{"u_0_5",       32'h0,          32'h5,         1'b0, 32'h00000000, 32'h00000000};

        rst = 1'b1;
        start = 1'b0;
        dividend = '0;
        divisor = '0;
        sign = 1'b0;
        #12;
        check("reset_ready", {31'd0, ready}, 32'd1);
        check("reset_quot", quotient, 32'd0);
        check("reset_rem", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 11; i++) begin
            do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].s, lat);
            check({vecs[i].name, "_lat"}, lat, 32);
            check({vecs[i].name, "_q"}, quotient, vecs[i].eq);
            check({vecs[i].name, "_r"}, remainder, vecs[i].er);
        end

        // idle: outputs hold the last result
        repeat (5) @(posedge clk);
        #1;
        check("idle_hold_q", quotient, 32'd0);
        check("idle_hold_ready", {31'd0, ready}, 32'd1);

        // start pulse and operand change while busy are ignored
        @(negedge clk);
        dividend = 32'd100; divisor = 32'd7; sign = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (8) @(posedge clk);
        @(negedge clk);
        dividend = 32'd999; divisor = 32'd3; sign = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 0;
        while (!ready && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        check("busy_ignore_ready", {31'd0, ready}, 32'd1);
        check("busy_ignore_q", quotient, 32'd14);
        check("busy_ignore_r", remainder, 32'd2);
        repeat (2) @(posedge clk);
        #1;
        check("busy_ignore_no_restart", {31'd0, ready}, 32'd1);

        // reset mid-operation takes effect immediately
        do_op("pre_rst", 32'd12345, 32'd11, 1'b0, lat);
        @(negedge clk);
        dividend = 32'h7777; divisor = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_q", quotient, 32'd0);
        check("midrst_r", remainder, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_op("post_rst", 32'd100, 32'd7, 1'b0, lat);
        check("post_rst_lat", lat, 32);
        check("post_rst_q", quotient, 32'd14);
        check("post_rst_r", remainder, 32'd2);

        // random ops through the expected queue
        for (int i = 1; i <= 20; i++) begin
            a = $urandom;
            if (i % 5 == 0) a = 32'h8000_0000;
            b = (i % 2 == 1) ? WIDTH'($urandom) : WIDTH'($urandom_range(0, 3));
            if (i == 10) b = 32'hFFFF_FFFF;
            s = 1'($urandom_range(0, 1));
            if (i == 10) s = 1'b1;
            ref_div(a, b, s, eq, er);
            exp_q.push_back(eq);
            exp_q.push_back(er);
            do_op("rand", a, b, s, lat);
            check("rand_lat", lat, 32);
            q = exp_q.pop_front();
            r = exp_q.pop_front();
            check("rand_q", quotient, q);
            check("rand_r", remainder, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
